// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the sequential matrix-multiply controller.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Counters and indices never shrink to zero width on degenerate shapes.
    function automatic int cnt_width(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + $clog2(k) + 1;
    endfunction

    function automatic int elem_offset(input int row, input int col, input int cols, input int dw);
        return (row * cols + col) * dw;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Start/operand request and streamed result beats between scheduler, controller and result buffer.
interface matmul_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int ACC_WIDTH  = matmul_pkg::acc_width(DATA_WIDTH, K)
);
    localparam int ROW_W = matmul_pkg::cnt_width(M);
    localparam int COL_W = matmul_pkg::cnt_width(N);

    logic                        start;
    logic [DATA_WIDTH*M*K-1:0]   matrix1;
    logic [DATA_WIDTH*K*N-1:0]   matrix2;
    logic                        busy;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_data;
    logic [ROW_W-1:0]            out_row;
    logic [COL_W-1:0]            out_col;
    logic                        out_last;
    logic                        done;

    modport master (
        output start, matrix1, matrix2, out_ready,
        input  busy, out_valid, out_data, out_row, out_col, out_last, done
    );

    modport slave (
        input  start, matrix1, matrix2, out_ready,
        output busy, out_valid, out_data, out_row, out_col, out_last, done
    );

endinterface

// File: rtl/mac_unit.sv
// Registered signed multiply-accumulate; sum exposes the value the next enabled edge will store.
module mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 19
) (
    input  logic                         clk_p,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  sum
);
    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] acc_reg;

    assign prod = PW'(a) * PW'(b);
    assign sum  = acc_reg + ACC_WIDTH'(prod);

    // Clear wins over enable so a new element always starts from zero.
    always_ff @(posedge clk_p) begin
        if (!rst_n || clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= sum;
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Computes C = A x B one element at a time on a single MAC, streaming C row-major on valid/ready.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, K)
) (
    input  logic              clk_p,
    input  logic              rst_n,
    matmul_seq_ctrl_if.slave  bus
);
    localparam int RW  = cnt_width(M);
    localparam int KW  = cnt_width(K);
    localparam int CW  = cnt_width(N);
    localparam int AOW = cnt_width(DATA_WIDTH * M * K);
    localparam int BOW = cnt_width(DATA_WIDTH * K * N);
    localparam logic [RW-1:0] I_LAST = RW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [CW-1:0] J_LAST = CW'(N - 1);

    state_t state_reg, state_next;

    logic [RW-1:0]               i_reg;
    logic [KW-1:0]               k_reg;
    logic [CW-1:0]               j_reg;
    logic [DATA_WIDTH*M*K-1:0]   a_reg;
    logic [DATA_WIDTH*K*N-1:0]   b_reg;
    logic signed [ACC_WIDTH-1:0] out_data_reg;

    logic                         accept, handshake, k_done, last_elem;
    logic [AOW-1:0]               a_off;
    logic [BOW-1:0]               b_off;
    logic signed [DATA_WIDTH-1:0] a_sel, b_sel;
    logic signed [ACC_WIDTH-1:0]  mac_sum;

    assign k_done    = (k_reg == K_LAST);
    assign last_elem = (i_reg == I_LAST) && (j_reg == J_LAST);
    assign a_off     = AOW'(elem_offset(int'(i_reg), int'(k_reg), K, DATA_WIDTH));
    assign b_off     = BOW'(elem_offset(int'(k_reg), int'(j_reg), N, DATA_WIDTH));
    assign a_sel     = a_reg[a_off +: DATA_WIDTH];
    assign b_sel     = b_reg[b_off +: DATA_WIDTH];

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .clr   (accept || handshake),
        .en    (state_reg == MAC),
        .a     (a_sel),
        .b     (b_sel),
        .sum   (mac_sum)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                if (k_done) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    handshake  = 1'b1;
                    state_next = last_elem ? FIN : MAC;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            i_reg        <= '0;
            k_reg        <= '0;
            j_reg        <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                i_reg <= '0;
                k_reg <= '0;
                j_reg <= '0;
            end
            if (state_reg == MAC) begin
                k_reg <= k_done ? '0 : k_reg + KW'(1);
                if (k_done) begin
                    out_data_reg <= mac_sum;
                end
            end
            // Indices advance only on handshake, so out_row/out_col hold while stalled.
            if (handshake) begin
                k_reg <= '0;
                if (j_reg == J_LAST) begin
                    j_reg <= '0;
                    i_reg <= (i_reg == I_LAST) ? '0 : i_reg + RW'(1);
                end else begin
                    j_reg <= j_reg + CW'(1);
                end
            end
        end
    end

    // Operand copies need no reset; they are always reloaded before use.
    always_ff @(posedge clk_p) begin
        if (accept) begin
            a_reg <= bus.matrix1;
            b_reg <= bus.matrix2;
        end
    end

    assign bus.busy      = (state_reg == MAC) || (state_reg == EMIT);
    assign bus.out_valid = (state_reg == EMIT);
    assign bus.out_data  = out_data_reg;
    assign bus.out_row   = i_reg;
    assign bus.out_col   = j_reg;
    assign bus.out_last  = (state_reg == EMIT) && last_elem;
    assign bus.done      = (state_reg == FIN);

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized self-checking bench for matmul_seq_ctrl against a plain nested-loop matrix product.
module tb_matmul_seq_ctrl;
    localparam int DW = 8;
    localparam int M  = 4;
    localparam int K  = 4;
    localparam int N  = 4;
    localparam int AW = 2 * DW + $clog2(K) + 1;
    localparam int AW1 = 2 * DW + 1;

    logic clk_p = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_p = ~clk_p;

    matmul_seq_ctrl_if #(.DATA_WIDTH(DW), .M(M), .K(K), .N(N), .ACC_WIDTH(AW)) bus ();
    matmul_seq_ctrl #(.DATA_WIDTH(DW), .M(M), .K(K), .N(N), .ACC_WIDTH(AW)) dut (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .bus   (bus)
    );

    matmul_seq_ctrl_if #(.DATA_WIDTH(DW), .M(1), .K(1), .N(1), .ACC_WIDTH(AW1)) bus1 ();
    matmul_seq_ctrl #(.DATA_WIDTH(DW), .M(1), .K(1), .N(1), .ACC_WIDTH(AW1)) dut1 (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int a_m [M][K];
    int b_m [K][N];

    task automatic step();
        @(posedge clk_p);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_m[i][k] = int'($urandom_range(255)) - 128;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_m[k][j] = int'($urandom_range(255)) - 128;
    endtask

    // Starts one multiplication from IDLE and follows it to done, checking every beat.
    task automatic run_matmul(input string name, input int ready_pct, input bit check_timing,
                              input bit glitch_start);
        logic [DW*M*K-1:0]    fa;
        logic [DW*K*N-1:0]    fb;
        logic signed [AW-1:0] exp_q[$];
        logic signed [AW-1:0] prev_data;
        logic [1:0]           prev_row, prev_col;
        bit                   prev_stall = 0;
        bit                   finished   = 0;
        bit                   rdy;
        int                   beats      = 0;
        int                   first_valid = -1;
        int                   done_cycle = -1;

        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) fa[(i*K+k)*DW +: DW] = a_m[i][k][DW-1:0];
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) fb[(k*N+j)*DW +: DW] = b_m[k][j][DW-1:0];
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int k = 0; k < K; k++) s += a_m[i][k] * b_m[k][j];
                exp_q.push_back(AW'(s));
            end
        end

        bus.matrix1   = fa;
        bus.matrix2   = fb;
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.start   = 1'b0;
        bus.matrix1 = ~fa;
        bus.matrix2 = ~fb;
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy_after_start: got %b want 1", name, bus.busy);
        end
        bus.out_ready = ($urandom_range(99) < ready_pct);

        for (int c = 1; c <= 3000 && !finished; c++) begin
            step();
            bus.start = 1'b0;
            if (glitch_start && (c == 5 || c == 40)) begin
                bus.start   = 1'b1;
                bus.matrix1 = {$urandom, $urandom, $urandom, $urandom};
                bus.matrix2 = {$urandom, $urandom, $urandom, $urandom};
            end
            if (prev_stall) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                    bus.out_row !== prev_row || bus.out_col !== prev_col) begin
                    tests_failed++;
                    $display("FAIL %s stall_hold: got v=%b d=%0d r=%0d c=%0d want v=1 d=%0d r=%0d c=%0d",
                             name, bus.out_valid, bus.out_data, bus.out_row, bus.out_col,
                             prev_data, prev_row, prev_col);
                end
            end
            if (bus.done === 1'b1) begin
                finished   = 1;
                done_cycle = c;
                tests_run++;
                if (beats != M * N || bus.busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s done_state: got beats=%0d busy=%b want beats=%0d busy=0",
                             name, beats, bus.busy, M * N);
                end
                if (check_timing) begin
                    tests_run++;
                    if (c != M * N * (K + 1)) begin
                        tests_failed++;
                        $display("FAIL %s done_cycle: got %0d want %0d", name, c, M * N * (K + 1));
                    end
                end
            end
            prev_stall = 0;
            if (bus.out_valid === 1'b1) begin
                if (first_valid < 0) begin
                    first_valid = c;
                    if (check_timing) begin
                        tests_run++;
                        if (c != K) begin
                            tests_failed++;
                            $display("FAIL %s first_beat_cycle: got %0d want %0d", name, c, K);
                        end
                    end
                end
                rdy = ($urandom_range(99) < ready_pct);
                if (rdy) begin
                    tests_run++;
                    if (beats >= M * N) begin
                        tests_failed++;
                        $display("FAIL %s extra_beat: got beat %0d want at most %0d", name, beats + 1, M * N);
                    end else if (bus.out_data !== exp_q[beats] || bus.out_row !== 2'(beats / N) ||
                                 bus.out_col !== 2'(beats % N) || bus.out_last !== (beats == M * N - 1)) begin
                        tests_failed++;
                        $display("FAIL %s beat%0d: got d=%0d r=%0d c=%0d last=%b want d=%0d r=%0d c=%0d last=%b",
                                 name, beats, bus.out_data, bus.out_row, bus.out_col, bus.out_last,
                                 exp_q[beats], beats / N, beats % N, beats == M * N - 1);
                    end
                    beats++;
                end else begin
                    prev_stall = 1;
                    prev_data  = bus.out_data;
                    prev_row   = bus.out_row;
                    prev_col   = bus.out_col;
                end
            end else begin
                rdy = ($urandom_range(99) < ready_pct);
            end
            bus.out_ready = rdy;
        end
        bus.start = 1'b0;
        if (!finished) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s timeout: got no done after 3000 cycles want done", name);
        end
        $display("[TB] %s: %0d beats, first beat at cycle %0d, done at cycle %0d", name, beats, first_valid, done_cycle);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.out_ready  = 1'b0;
        bus.matrix1    = '0;
        bus.matrix2    = '0;
        bus1.start     = 1'b0;
        bus1.out_ready = 1'b0;
        bus1.matrix1   = '0;
        bus1.matrix2   = '0;
        step();
        step();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.done !== 1'b0 ||
            bus.out_data !== '0 || bus.out_row !== '0 || bus.out_col !== '0) begin
            tests_failed++;
            $display("FAIL reset_4x4: got busy=%b v=%b last=%b done=%b d=%0d r=%0d c=%0d want all 0",
                     bus.busy, bus.out_valid, bus.out_last, bus.done, bus.out_data, bus.out_row, bus.out_col);
        end
        tests_run++;
        if (bus1.busy !== 1'b0 || bus1.out_valid !== 1'b0 || bus1.done !== 1'b0 || bus1.out_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_1x1: got busy=%b v=%b done=%b d=%0d want all 0",
                     bus1.busy, bus1.out_valid, bus1.done, bus1.out_data);
        end
        rst_n = 1'b1;
        step();
        $display("[TB] reset: checked");
    endtask

    task automatic test_identity();
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_m[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_m[k][j] = k * N + j;
        run_matmul("identity", 100, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_signed_extremes();
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_m[i][k] = -128;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_m[k][j] = -128;
        run_matmul("neg_times_neg", 100, 1'b1, 1'b0);
        step();
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_m[k][j] = 127;
        run_matmul("neg_times_pos", 100, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 2; r++) begin
            fill_random();
            run_matmul("backpressure", 30, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic test_start_while_busy();
        fill_random();
        run_matmul("start_while_busy", 100, 1'b1, 1'b1);
        step();
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_matmul("b2b_first", 100, 1'b1, 1'b0);
        // Currently in the FIN cycle: this start must be dropped.
        bus.start   = 1'b1;
        bus.matrix1 = {$urandom, $urandom, $urandom, $urandom};
        step();
        bus.start = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_on_fin: got busy=%b v=%b done=%b want 0 0 0", bus.busy, bus.out_valid, bus.done);
        end
        fill_random();
        run_matmul("b2b_second", 60, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [DW*M*K-1:0] fa;
        int  emits      = 0;
        bit  prev_valid = 0;
        bit  hit        = 0;
        bit  bad        = 0;
        fill_random();
        for (int i = 0; i < M * K; i++) fa[i*DW +: DW] = DW'($urandom);
        bus.matrix1   = fa;
        bus.matrix2   = ~fa;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (bus.out_valid === 1'b1 && !prev_valid) emits++;
            prev_valid = bus.out_valid;
            if (emits == 3) begin
                hit           = 1;
                bus.out_ready = 1'b0;
                rst_n         = 1'b0;
            end
            step();
        end
        tests_run++;
        if (!hit || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: got hit=%b v=%b busy=%b done=%b want 1 0 0 0",
                     hit, bus.out_valid, bus.busy, bus.done);
        end
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) bad = 1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL reset_quiet: got activity after abort want none");
        end
        $display("[TB] reset_mid_run: aborted at emit %0d", emits);
        fill_random();
        run_matmul("after_reset", 100, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_shape_corner();
        int av = -3;
        int bv = 5;
        logic signed [AW1-1:0] want;
        want           = AW1'(av * bv);
        bus1.matrix1   = av[DW-1:0];
        bus1.matrix2   = bv[DW-1:0];
        bus1.start     = 1'b1;
        bus1.out_ready = 1'b1;
        step();
        bus1.start = 1'b0;
        tests_run++;
        if (bus1.busy !== 1'b1 || bus1.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL corner_mac: got busy=%b v=%b want 1 0", bus1.busy, bus1.out_valid);
        end
        step();
        tests_run++;
        if (bus1.out_valid !== 1'b1 || bus1.out_data !== want || bus1.out_last !== 1'b1 ||
            bus1.out_row !== 1'b0 || bus1.out_col !== 1'b0) begin
            tests_failed++;
            $display("FAIL corner_beat: got v=%b d=%0d last=%b want v=1 d=%0d last=1",
                     bus1.out_valid, bus1.out_data, bus1.out_last, want);
        end
        step();
        tests_run++;
        if (bus1.done !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL corner_done: got done=%b v=%b busy=%b want 1 0 0", bus1.done, bus1.out_valid, bus1.busy);
        end
        step();
        tests_run++;
        if (bus1.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL corner_done_pulse: got done=%b want 0", bus1.done);
        end
        bus1.out_ready = 1'b0;
        $display("[TB] shape_corner: beat %0d", bus1.out_data);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed_extremes();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_shape_corner();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
